// File: rtl/p4_operand_stage_if.sv
// Operand-stage bus: register-file access, operand load/select controls and ALU-facing outputs.
interface p4_operand_stage_if;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic [2:0]  readnum;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [15:0] sximm5;
  logic        consume;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [15:0] data_out;
  logic        ready;

  modport master (
    output write, writenum, data_in, readnum, loada, loadb, shift, asel, bsel, sximm5, consume,
    input  Ain, Bin, data_out, ready
  );

  modport slave (
    input  write, writenum, data_in, readnum, loada, loadb, shift, asel, bsel, sximm5, consume,
    output Ain, Bin, data_out, ready
  );
endinterface

// File: rtl/p4_operand_stage.sv
// Operand stage: 8x16 register file, A/B operand latches, B-path shifter and
// a load-tracking FSM that raises ready once both operands are captured.
module p4_operand_stage (
  input logic                  clk,
  input logic                  rst_n,
  p4_operand_stage_if.slave    bus
);

  typedef enum logic [1:0] {StNone, StAOnly, StBOnly, StBoth} state_e;

  logic [15:0] regs_q [8];
  logic [15:0] a_q, b_q;
  logic [15:0] b_shifted;
  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        a_ok, b_ok, a_nxt, b_nxt;

  assign bus.data_out = regs_q[bus.readnum];

  // A/B sample the pre-edge read value, so a same-index write is not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
      a_q <= 16'h0000;
      b_q <= 16'h0000;
    end else begin
      if (bus.write) regs_q[bus.writenum] <= bus.data_in;
      if (bus.loada) a_q <= bus.data_out;
      if (bus.loadb) b_q <= bus.data_out;
    end
  end

  always_comb begin
    b_shifted = b_q;
    unique case (bus.shift)
      2'b00:   b_shifted = b_q;
      2'b01:   b_shifted = {b_q[14:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_q[15:1]};
      default: b_shifted = {b_q[15], b_q[15:1]};
    endcase
  end

  assign bus.Ain = bus.asel ? 16'h0000 : a_q;
  assign bus.Bin = bus.bsel ? bus.sximm5 : b_shifted;

  // Load beats consume on each flag independently.
  always_comb begin
    a_ok  = (state_q == StAOnly) || (state_q == StBoth);
    b_ok  = (state_q == StBOnly) || (state_q == StBoth);
    a_nxt = bus.loada | (a_ok & ~bus.consume);
    b_nxt = bus.loadb | (b_ok & ~bus.consume);
    state_d = StNone;
    unique case ({a_nxt, b_nxt})
      2'b00:   state_d = StNone;
      2'b10:   state_d = StAOnly;
      2'b01:   state_d = StBOnly;
      default: state_d = StBoth;
    endcase
    ready_d = a_nxt & b_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StNone;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready = ready_q;

endmodule

// File: tb/tb_p4_operand_stage.sv
// Directed bench for p4_operand_stage: register file, read-before-write, shifter,
// operand selects, ready tracking and asynchronous reset.
module tb_p4_operand_stage;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  p4_operand_stage_if bus ();

  p4_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.write    = 1'b0;
    bus.writenum = 3'd0;
    bus.data_in  = 16'h0000;
    bus.readnum  = 3'd0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.shift    = 2'b00;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.sximm5   = 16'h0000;
    bus.consume  = 1'b0;
  endtask

  // Advance one edge and settle 1 time unit after it; controls return to idle.
  task automatic step();
    @(posedge clk);
    #1;
    bus.write   = 1'b0;
    bus.loada   = 1'b0;
    bus.loadb   = 1'b0;
    bus.consume = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    bus.write    = 1'b1;
    bus.writenum = idx;
    bus.data_in  = val;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    total++;
    if (bus.Ain !== 16'h0000) $display("FAIL reset_ain got %h want 0000", bus.Ain);
    else passed++;
    total++;
    if (bus.Bin !== 16'h0000) $display("FAIL reset_bin got %h want 0000", bus.Bin);
    else passed++;
    total++;
    if (bus.data_out !== 16'h0000) $display("FAIL reset_dout got %h want 0000", bus.data_out);
    else passed++;
    total++;
    if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready);
    else passed++;
    bus.bsel   = 1'b1;
    bus.sximm5 = 16'h1357;
    #1;
    total++;
    if (bus.Bin !== 16'h1357) $display("FAIL reset_bin_imm got %h want 1357", bus.Bin);
    else passed++;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    write_reg(3'd3, 16'h1234);
    bus.readnum = 3'd3;
    #1;
    total++;
    if (bus.data_out !== 16'h1234) $display("FAIL wr_r3 got %h want 1234", bus.data_out);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        bus.readnum = 3'(i);
        #1;
        total++;
        if (bus.data_out !== 16'h0000) $display("FAIL wr_other r%0d got %h want 0000", i, bus.data_out);
        else passed++;
      end
    end
  endtask

  task automatic test_read_before_write();
    write_reg(3'd2, 16'h00AA);
    bus.write    = 1'b1;
    bus.writenum = 3'd2;
    bus.data_in  = 16'h5555;
    bus.readnum  = 3'd2;
    bus.loada    = 1'b1;
    step();
    total++;
    if (bus.Ain !== 16'h00AA) $display("FAIL rbw_a got %h want 00aa", bus.Ain);
    else passed++;
    total++;
    if (bus.data_out !== 16'h5555) $display("FAIL rbw_dout got %h want 5555", bus.data_out);
    else passed++;
  endtask

  task automatic test_shifter();
    logic [15:0] exp_tab [4];
    exp_tab[0] = 16'h8001;
    exp_tab[1] = 16'h0002;
    exp_tab[2] = 16'h4000;
    exp_tab[3] = 16'hC000;
    write_reg(3'd4, 16'h8001);
    bus.readnum = 3'd4;
    bus.loadb   = 1'b1;
    step();
    bus.bsel = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.shift = 2'(s);
      #1;
      total++;
      if (bus.Bin !== exp_tab[s]) $display("FAIL shift_%0d got %h want %h", s, bus.Bin, exp_tab[s]);
      else passed++;
    end
    bus.shift = 2'b00;
  endtask

  task automatic test_selects();
    write_reg(3'd6, 16'h7FFF);
    bus.readnum = 3'd6;
    bus.loada   = 1'b1;
    step();
    bus.asel   = 1'b1;
    bus.bsel   = 1'b1;
    bus.sximm5 = 16'hFFF0;
    #1;
    total++;
    if (bus.Ain !== 16'h0000) $display("FAIL sel_ain_zero got %h want 0000", bus.Ain);
    else passed++;
    total++;
    if (bus.Bin !== 16'hFFF0) $display("FAIL sel_bin_imm got %h want fff0", bus.Bin);
    else passed++;
    bus.asel = 1'b0;
    #1;
    total++;
    if (bus.Ain !== 16'h7FFF) $display("FAIL sel_ain_a got %h want 7fff", bus.Ain);
    else passed++;
    bus.bsel = 1'b0;
  endtask

  task automatic check_ready(input string name, input logic exp);
    total++;
    if (bus.ready !== exp) $display("FAIL %s got %b want %b", name, bus.ready, exp);
    else passed++;
  endtask

  task automatic test_ready();
    bus.consume = 1'b1;
    step();
    check_ready("rdy_cleared", 1'b0);
    bus.loada = 1'b1;                    // cycle 1
    step();
    check_ready("rdy_c2", 1'b0);
    step();                              // cycle 2 idle
    check_ready("rdy_c3", 1'b0);
    bus.loadb = 1'b1;                    // cycle 3
    step();
    check_ready("rdy_c4", 1'b1);
    step();                              // cycle 4 idle
    check_ready("rdy_c5", 1'b1);
    bus.consume = 1'b1;                  // cycle 5
    step();
    check_ready("rdy_c6", 1'b0);
    bus.loada   = 1'b1;                  // cycle 6
    bus.consume = 1'b1;
    step();
    check_ready("rdy_c7", 1'b0);
    bus.loadb = 1'b1;                    // cycle 7
    step();
    check_ready("rdy_c8", 1'b1);
    // Consume with a partial load pending drops the partial flag.
    bus.consume = 1'b1;
    step();
    bus.loada = 1'b1;
    step();
    bus.consume = 1'b1;
    step();
    bus.loadb = 1'b1;
    step();
    check_ready("rdy_partial_cleared", 1'b0);
    bus.consume = 1'b1;
    step();
    bus.loada = 1'b1;
    bus.loadb = 1'b1;
    step();
    check_ready("rdy_both_same_edge", 1'b1);
  endtask

  task automatic test_async_reset();
    write_reg(3'd5, 16'hBEEF);
    bus.readnum = 3'd5;
    bus.loada   = 1'b1;
    bus.loadb   = 1'b1;
    step();
    check_ready("arst_pre_ready", 1'b1);
    total++;
    if (bus.Bin !== 16'hBEEF) $display("FAIL arst_pre_b got %h want beef", bus.Bin);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    check_ready("arst_ready", 1'b0);
    total++;
    if (bus.Ain !== 16'h0000) $display("FAIL arst_a got %h want 0000", bus.Ain);
    else passed++;
    total++;
    if (bus.Bin !== 16'h0000) $display("FAIL arst_b got %h want 0000", bus.Bin);
    else passed++;
    total++;
    if (bus.data_out !== 16'h0000) $display("FAIL arst_r5 got %h want 0000", bus.data_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_ready("arst_after_release", 1'b0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_write_read();
    test_read_before_write();
    test_shifter();
    test_selects();
    test_ready();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
